// File: rtl/stoch_ctrl_pkg.sv
// Shared types and default widths for the stochastic run controller.
package stoch_ctrl_pkg;

  localparam int LEN_WIDTH_DEF    = 16;
  localparam int WARM_WIDTH_DEF   = 8;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WARMUP,
    MEASURE,
    DONE
  } stoch_run_state_t;

endpackage

// File: rtl/stoch_ones_counter.sv
// Ones counter for the measure window: synchronous clear, increment enable,
// asynchronous reset. Clear has priority over increment.
module stoch_ones_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Counter register: clear wins, otherwise step by one when enabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/stoch_run_ctrl.sv
// Run sequencer for a stochastic datapath: flush (dp_nrst low), discarded
// warm-up window, then a measure window whose dp_y ones-count is returned.
//
// Handshake: start is accepted only in IDLE or DONE with abort low; len and
// warmup are captured on that edge. busy is high from the cycle after an
// accepted start until the run ends; done is a one-cycle pulse in which
// result/result_valid already hold the new count. abort while busy returns
// to IDLE with no done pulse and leaves result untouched.
module stoch_run_ctrl
  import stoch_ctrl_pkg::*;
#(
  parameter int LEN_WIDTH    = LEN_WIDTH_DEF,
  parameter int WARM_WIDTH   = WARM_WIDTH_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [WARM_WIDTH-1:0] warmup,
  input  logic                 dp_y,
  output logic                 dp_nrst,
  output logic                 dp_en,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic [2:0]           dbg_state
);

  // One phase counter serves flush, warm-up and measure, so it must hold the
  // widest of the lengths (FLUSH_CYCLES is assumed to fit).
  localparam int PH_W = (LEN_WIDTH > WARM_WIDTH) ? LEN_WIDTH : WARM_WIDTH;
  localparam logic [PH_W-1:0] FLUSH_LOAD = PH_W'(FLUSH_CYCLES - 1);

  stoch_run_state_t     r_state;
  stoch_run_state_t     w_next;
  logic [PH_W-1:0]      r_phase;
  logic [PH_W-1:0]      w_phase_nxt;
  logic [LEN_WIDTH-1:0] r_len;
  logic [WARM_WIDTH-1:0] r_warm;
  logic [LEN_WIDTH-1:0] r_result;
  logic                 r_result_valid;
  logic                 w_capture;
  logic                 w_ones_clr;
  logic                 w_ones_inc;
  logic                 w_load_result;
  logic                 w_phase_zero;
  logic [PH_W-1:0]      w_warm_ext;
  logic [PH_W-1:0]      w_len_ext;
  logic [LEN_WIDTH-1:0] w_ones_count;
  logic [LEN_WIDTH-1:0] w_result_nxt;

  assign w_phase_zero = (r_phase == '0);
  assign w_warm_ext   = PH_W'(r_warm);
  assign w_len_ext    = PH_W'(r_len);

  // The final measure cycle's dp_y is folded in here so result is ready on
  // the DONE entry edge; runs with len==0 report zero.
  assign w_result_nxt = (r_state == MEASURE) ? (w_ones_count + LEN_WIDTH'(dp_y)) : '0;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, phase-counter control and state-decoded outputs.
  always_comb begin
    w_next        = r_state;
    w_phase_nxt   = r_phase;
    w_capture     = 1'b0;
    w_ones_clr    = 1'b0;
    w_ones_inc    = 1'b0;
    w_load_result = 1'b0;
    dp_nrst       = 1'b0;
    dp_en         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_capture   = 1'b1;
          w_phase_nxt = FLUSH_LOAD;
          w_next      = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (abort) begin
          w_next = IDLE;
        end else if (w_phase_zero) begin
          w_ones_clr = 1'b1;
          if (r_warm != '0) begin
            w_next      = WARMUP;
            w_phase_nxt = w_warm_ext - PH_W'(1);
          end else if (r_len != '0) begin
            w_next      = MEASURE;
            w_phase_nxt = w_len_ext - PH_W'(1);
          end else begin
            w_next        = DONE;
            w_load_result = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase - PH_W'(1);
        end
      end
      WARMUP: begin
        dp_nrst = 1'b1;
        dp_en   = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          w_next = IDLE;
        end else if (w_phase_zero) begin
          if (r_len != '0) begin
            w_next      = MEASURE;
            w_phase_nxt = w_len_ext - PH_W'(1);
          end else begin
            w_next        = DONE;
            w_load_result = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase - PH_W'(1);
        end
      end
      MEASURE: begin
        dp_nrst    = 1'b1;
        dp_en      = 1'b1;
        busy       = 1'b1;
        w_ones_inc = dp_y;
        if (abort) begin
          w_next = IDLE;
        end else if (w_phase_zero) begin
          w_next        = DONE;
          w_load_result = 1'b1;
        end else begin
          w_phase_nxt = r_phase - PH_W'(1);
        end
      end
      DONE: begin
        dp_nrst = 1'b1;
        done    = 1'b1;
        if (start && !abort) begin
          w_capture   = 1'b1;
          w_phase_nxt = FLUSH_LOAD;
          w_next      = FLUSH;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Phase counter, captured run lengths and the result holding register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_phase        <= '0;
      r_len          <= '0;
      r_warm         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_capture) begin
        r_len  <= len;
        r_warm <= warmup;
      end
      if (w_load_result) begin
        r_result       <= w_result_nxt;
        r_result_valid <= 1'b1;
      end
    end
  end

  stoch_ones_counter #(
    .W (LEN_WIDTH)
  ) u_ones (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (w_ones_clr),
    .i_inc   (w_ones_inc),
    .o_count (w_ones_count)
  );

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign dbg_state    = r_state;

endmodule

// File: doc/stoch_run_ctrl.md
Name: stoch_run_ctrl

Overview:
- Sequences one evaluation run of a stochastic datapath, such as the stochastic adder.
- Clears the datapath's saturating counter, runs the bitstreams through a discarded warm-up window, then counts output 1s over a programmed length.
- Returns the ones-count as the fixed-point estimate, using a start/busy/done handshake.
- Sits between the host/config logic and the stochastic datapath plus its SNGs.

Parameters:
- LEN_WIDTH, 16, width of measure length and of result.
- WARM_WIDTH, 8, width of warm-up length.
- FLUSH_CYCLES, 2, number of cycles dp_nrst is held low before each run (must be >= 1).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  run request; accepted only in IDLE or DONE.
- abort  input  1  cancels an in-progress run.
- len  input  LEN_WIDTH  number of measure cycles; captured on the accepted start.
- warmup  input  WARM_WIDTH  number of discarded cycles; captured on the accepted start.
- dp_y  input  1  datapath output bitstream.
- dp_nrst  output  1  active-low synchronous clear to the datapath.
- dp_en  output  1  enables the SNGs and datapath stepping.
- busy  output  1  high in FLUSH, WARMUP and MEASURE.
- done  output  1  one-cycle pulse at the end of a completed run.
- result  output  LEN_WIDTH  ones-count of the last completed run.
- result_valid  output  1  result holds a completed run.

Behaviour:
- Reset: RST asynchronously forces the state to IDLE.
  - dp_nrst=0, dp_en=0, busy=0, done=0, result=0, result_valid=0.
  - The phase counter and ones counter are cleared.
- Outputs dp_nrst, dp_en, busy and done decode directly from the state register, so they add no extra latency.
- States: IDLE, FLUSH, WARMUP, MEASURE, DONE.
- IDLE: dp_nrst=0, dp_en=0. On start=1 and abort=0:
  - Capture len and warmup.
  - Load the phase counter with FLUSH_CYCLES-1.
  - Go to FLUSH.
- FLUSH: dp_nrst=0, dp_en=0, busy=1.
  - When the phase counter reaches 0: clear the ones counter and go to WARMUP.
  - If warmup==0, go directly to MEASURE instead.
  - If warmup==0 and len==0, go to DONE instead.
- WARMUP: dp_nrst=1, dp_en=1, dp_y ignored. Lasts exactly warmup cycles, then MEASURE (or DONE if len==0).
- MEASURE: dp_nrst=1, dp_en=1.
  - In each cycle the ones counter adds dp_y.
  - Lasts exactly len cycles, then DONE.
  - The count is at most len, so there is no overflow and no saturation logic.
- DONE: lasts one cycle. done=1, busy=0, dp_en=0, dp_nrst=1.
  - result and result_valid are registered at the entry edge, so they are visible during DONE.
  - Next state is FLUSH if start=1, else IDLE (back-to-back runs).
- Timing: with start sampled at edge 0, for F=FLUSH_CYCLES, W=warmup, L=len:
  - FLUSH occupies cycles 1..F.
  - WARMUP occupies F+1..F+W.
  - MEASURE occupies F+W+1..F+W+L.
  - done=1 in cycle F+W+L+1.
- start while busy: ignored, with no queueing.
- abort=1 in FLUSH, WARMUP or MEASURE:
  - Go to IDLE at the next edge.
  - No done pulse.
  - result and result_valid keep their previous values.
- abort in IDLE or DONE: no effect; it wins over a simultaneous start (the next state is IDLE).
- Phase-counter wrap is impossible: each phase is terminated at 0 before it decrements.
- RST mid-run: immediate return to reset values with no clock needed; the run is lost.

Decomposition:
- Package stoch_ctrl_pkg holds:
  - the typedef enum logic [2:0] stoch_run_state_t {IDLE, FLUSH, WARMUP, MEASURE, DONE};
  - the default width constants.
- One sub-module, stoch_ones_counter: LEN_WIDTH-wide counter with a synchronous clear input, an increment-enable input and async RST. It is instantiated for the ones count.
- The phase counter stays inline.

Test Plan:
- Basic run: RST pulse, start with len=8, warmup=4, dp_y=1 constant.
  - Expect dp_nrst=0 in cycles 1–2 and dp_en=1 in cycles 3–14.
  - Expect done in cycle 15, with result=8 and result_valid=1.
- Sparse stream: len=16, warmup=0, dp_y=1 on every 4th MEASURE cycle.
  - Expect result=4 and done in cycle 19.
- Zero lengths: len=0, warmup=0.
  - Expect FLUSH for 2 cycles, then DONE in cycle 3 with result=0 and dp_en never high.
- Abort: a completed run leaves result=8; start a new run and assert abort in its 3rd MEASURE cycle.
  - Expect IDLE and dp_nrst=0 at the next edge, no done pulse, and result still 8.
- Handshake edges:
  - start held high through the whole run is ignored while busy.
  - start in the DONE cycle goes straight to FLUSH, with dp_nrst=0 the next cycle.
  - start+abort together in IDLE leaves the block in IDLE.
- Async reset: RST raised mid-MEASURE between clock edges.
  - busy, dp_en, done, result and result_valid drop to 0 before the next edge, and dp_nrst drops to 0.
